mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter MEM_SIZE, default 1024, meaning data memory size in bytes (power of two, >8).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port req_valid, input, 1, requester has a transfer.
REQ-005 SHALL have port req_ready, output, 1, unit can accept a request.
REQ-006 SHALL have port req_write, input, 1: 1 = store, 0 = load.
REQ-007 SHALL have port req_addr, input, 64, byte address; any alignment.
REQ-008 SHALL have port req_size, input, 4, bytes to transfer; legal values 1, 2, 4, 8.
REQ-009 SHALL have port req_wdata, input, 64, store data, little-endian, low req_size bytes used.
REQ-010 SHALL have port req_signed, input, 1: sign-extend load result when 1.
REQ-011 SHALL have port resp_valid, output, 1, one-cycle completion pulse.
REQ-012 SHALL have port resp_rdata, output, 64, load result.
REQ-013 SHALL have port resp_err, output, 1, request rejected; valid with resp_valid.
REQ-014 SHALL have ports mem_address (64), mem_write_enable (1), mem_read_enable (1), mem_write_data (64), mem_xfer_size (4), all outputs, driving the data memory.
REQ-015 SHALL have port mem_read_data, input, 64, combinational read data from the data memory.

Function
REQ-016 SHALL use states IDLE, ALIGNED, SPLIT, RESP; req_ready = 1 only in IDLE.
REQ-017 SHALL accept a request on a rising edge where req_valid and req_ready are both 1, latching all req_* fields; req_valid outside IDLE is ignored.
REQ-018 SHALL flag an error when req_size is not 1/2/4/8, or when req_addr + req_size (computed 65 bits wide, no wrap) > MEM_SIZE.
REQ-019 SHALL go IDLE->RESP with resp_err = 1 on error, with no memory enable asserted.
REQ-020 SHALL go IDLE->ALIGNED when the request is legal and req_addr mod req_size = 0.
REQ-021 SHALL go IDLE->SPLIT when the request is legal and req_addr mod req_size != 0.
REQ-022 SHALL, in ALIGNED, drive for exactly one cycle: mem_address = addr, mem_xfer_size = size, mem_write_data = wdata, write enable = write, read enable = ~write; a load captures mem_read_data at the closing edge; then go to RESP.
REQ-023 SHALL, in SPLIT, use byte counter k = 0..size-1, one cycle per byte: mem_address = addr+k, mem_xfer_size = 1, mem_write_data[7:0] = wdata byte k (upper bits 0), enables as in REQ-022.
REQ-024 SHALL, for a split load, capture mem_read_data[7:0] into result byte k; after k = size-1 go to RESP.
REQ-025 SHALL hold resp_valid = 1 for exactly one cycle in RESP, then return to IDLE.
REQ-026 SHALL, on a legal load, drive resp_rdata as the size-byte result zero-extended (req_signed = 0) or sign-extended from bit 8*size-1 (req_signed = 1).
REQ-027 SHALL drive resp_rdata = 0 for stores and errors.
REQ-028 SHALL drive all mem_* outputs to 0 outside ALIGNED/SPLIT, never X.
REQ-029 SHALL, with acceptance edge E0, assert resp_valid in the cycle after E1 for an aligned request, after E(size) for a split request, and after E0 for an error.
REQ-030 SHALL never issue an access violating memory alignment or bounds rules.

Reset
REQ-031 SHALL, while reset is 1, immediately force: state IDLE, k = 0, resp_valid = 0, resp_err = 0, resp_rdata = 0, all mem_* = 0; req_ready = 1 after reset deasserts.
REQ-032 SHALL abandon an in-flight request on reset with no response; split bytes already written remain written.

Verification
REQ-033 Store size 8, 0x1122334455667788 @0x10 -> one mem cycle, resp after E1; then load size 8 @0x10 -> resp_rdata 0x1122334455667788, resp_err 0.
REQ-034 Store size 4, 0xA1B2C3D4 @0x21 -> four size-1 writes, 0x21..0x24 = D4, C3, B2, A1; load signed -> 0xFFFFFFFFA1B2C3D4; load unsigned -> 0x00000000A1B2C3D4; resp after E4.
REQ-035 Size 3 @0x0 -> resp_err 1, resp after E0, no enables seen.
REQ-036 Size 8 @0x3FC -> resp_err 1; size 2 @0xFFFFFFFFFFFFFFFF -> resp_err 1 (no wrap).
REQ-037 Reset mid-SPLIT after two bytes of an 8-byte store @0x101 -> outputs zero at once, no resp_valid, only 0x101..0x102 modified.
REQ-038 req_valid held high across two back-to-back requests -> each accepted only in IDLE, exactly one resp_valid pulse per request, responses in order.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store unit between a single requester and a byte-addressed data memory.
// Aligned accesses take one memory cycle. Misaligned accesses are split into
// one byte-wide access per byte. Illegal sizes or out-of-range requests are
// rejected without touching memory.
module mem_access_unit #(
   parameter int unsigned MEM_SIZE = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [63:0] req_addr,
   input  logic [3:0]  req_size,
   input  logic [63:0] req_wdata,
   input  logic        req_signed,
   output logic        resp_valid,
   output logic [63:0] resp_rdata,
   output logic        resp_err,
   output logic [63:0] mem_address,
   output logic        mem_write_enable,
   output logic        mem_read_enable,
   output logic [63:0] mem_write_data,
   output logic [3:0]  mem_xfer_size,
   input  logic [63:0] mem_read_data
);

   typedef enum logic [1:0] {IDLE, ALIGNED, SPLIT, RESP} state_t;

   state_t      state;
   logic [2:0]  k;
   logic [63:0] addr_q;
   logic [3:0]  size_q;
   logic [63:0] wdata_q;
   logic        write_q;
   logic        sgn_q;
   logic [63:0] rbuf;

   logic        size_ok;
   logic [64:0] end_addr;
   logic        req_err;
   logic        misaligned;
   logic        last_byte;
   logic [2:0]  k_next;
   logic [63:0] rbuf_next;

   // Truncate to the access size and zero- or sign-extend to 64 bits.
   function automatic logic [63:0] extend(input logic [63:0] d, input logic [3:0] sz,
                                          input logic sgn);
      logic [63:0] r;
      case (sz)
         4'd1:    r = {{56{sgn & d[7]}}, d[7:0]};
         4'd2:    r = {{48{sgn & d[15]}}, d[15:0]};
         4'd4:    r = {{32{sgn & d[31]}}, d[31:0]};
         default: r = d;
      endcase
      return r;
   endfunction

   assign req_ready = (state == IDLE);

   // Request legality, alignment and split-progress decode.
   always_comb begin
      size_ok    = (req_size == 4'd1) || (req_size == 4'd2) ||
                   (req_size == 4'd4) || (req_size == 4'd8);
      // 65-bit sum so an address near the top of the space cannot wrap into range.
      end_addr   = {1'b0, req_addr} + {61'b0, req_size};
      req_err    = !size_ok || (end_addr > 65'(MEM_SIZE));
      misaligned = (req_addr[3:0] & (req_size - 4'd1)) != 4'd0;
      last_byte  = ({1'b0, k} == (size_q - 4'd1));
      k_next     = k + 3'd1;
      rbuf_next  = rbuf;
      rbuf_next[{k, 3'b000} +: 8] = mem_read_data[7:0];
   end

   // Control FSM with registered memory-side and response outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state            <= IDLE;
         k                <= 3'd0;
         addr_q           <= '0;
         size_q           <= '0;
         wdata_q          <= '0;
         write_q          <= 1'b0;
         sgn_q            <= 1'b0;
         rbuf             <= '0;
         resp_valid       <= 1'b0;
         resp_err         <= 1'b0;
         resp_rdata       <= '0;
         mem_address      <= '0;
         mem_write_enable <= 1'b0;
         mem_read_enable  <= 1'b0;
         mem_write_data   <= '0;
         mem_xfer_size    <= '0;
      end else begin
         case (state)
            IDLE: begin
               resp_valid <= 1'b0;
               resp_err   <= 1'b0;
               resp_rdata <= '0;
               if (req_valid) begin
                  addr_q  <= req_addr;
                  size_q  <= req_size;
                  wdata_q <= req_wdata;
                  write_q <= req_write;
                  sgn_q   <= req_signed;
                  rbuf    <= '0;
                  k       <= 3'd0;
                  if (req_err) begin
                     state      <= RESP;
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b1;
                  end else begin
                     mem_address      <= req_addr;
                     mem_write_enable <= req_write;
                     mem_read_enable  <= ~req_write;
                     if (misaligned) begin
                        state          <= SPLIT;
                        mem_xfer_size  <= 4'd1;
                        mem_write_data <= {56'b0, req_wdata[7:0]};
                     end else begin
                        state          <= ALIGNED;
                        mem_xfer_size  <= req_size;
                        mem_write_data <= req_wdata;
                     end
                  end
               end
            end
            ALIGNED: begin
               state            <= RESP;
               resp_valid       <= 1'b1;
               resp_err         <= 1'b0;
               resp_rdata       <= write_q ? 64'd0 : extend(mem_read_data, size_q, sgn_q);
               mem_address      <= '0;
               mem_write_enable <= 1'b0;
               mem_read_enable  <= 1'b0;
               mem_write_data   <= '0;
               mem_xfer_size    <= '0;
            end
            SPLIT: begin
               rbuf <= rbuf_next;
               if (last_byte) begin
                  state            <= RESP;
                  k                <= 3'd0;
                  resp_valid       <= 1'b1;
                  resp_err         <= 1'b0;
                  resp_rdata       <= write_q ? 64'd0 : extend(rbuf_next, size_q, sgn_q);
                  mem_address      <= '0;
                  mem_write_enable <= 1'b0;
                  mem_read_enable  <= 1'b0;
                  mem_write_data   <= '0;
                  mem_xfer_size    <= '0;
               end else begin
                  k              <= k_next;
                  mem_address    <= addr_q + {61'b0, k_next};
                  mem_write_data <= {56'b0, wdata_q[{k_next, 3'b000} +: 8]};
               end
            end
            RESP: begin
               state      <= IDLE;
               resp_valid <= 1'b0;
               resp_err   <= 1'b0;
               resp_rdata <= '0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: byte memory model, scoreboard of
// expected responses, table of single transactions plus reset and
// back-to-back sequences.
module tb_mem_access_unit;

   localparam int unsigned MEM_SIZE = 1024;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [63:0] req_addr = '0;
   logic [3:0]  req_size = '0;
   logic [63:0] req_wdata = '0;
   logic        req_signed = 1'b0;
   logic        resp_valid;
   logic [63:0] resp_rdata;
   logic        resp_err;
   logic [63:0] mem_address;
   logic        mem_write_enable;
   logic        mem_read_enable;
   logic [63:0] mem_write_data;
   logic [3:0]  mem_xfer_size;
   logic [63:0] mem_read_data;

   mem_access_unit #(.MEM_SIZE(MEM_SIZE)) dut (
      .clk              (clk),
      .reset            (reset),
      .req_valid        (req_valid),
      .req_ready        (req_ready),
      .req_write        (req_write),
      .req_addr         (req_addr),
      .req_size         (req_size),
      .req_wdata        (req_wdata),
      .req_signed       (req_signed),
      .resp_valid       (resp_valid),
      .resp_rdata       (resp_rdata),
      .resp_err         (resp_err),
      .mem_address      (mem_address),
      .mem_write_enable (mem_write_enable),
      .mem_read_enable  (mem_read_enable),
      .mem_write_data   (mem_write_data),
      .mem_xfer_size    (mem_xfer_size),
      .mem_read_data    (mem_read_data)
   );

   always #5 clk = ~clk;

   // Byte-addressed data memory model
   logic [7:0] mem [MEM_SIZE] = '{default: 8'h00};

   always_comb begin
      mem_read_data = '0;
      for (int i = 0; i < 8; i++) begin
         if (i < int'(mem_xfer_size) && (mem_address + 64'(i)) < 64'(MEM_SIZE))
            mem_read_data[8*i +: 8] = mem[int'(mem_address) + i];
      end
   end

   always @(posedge clk) begin
      if (mem_write_enable) begin
         for (int i = 0; i < 8; i++) begin
            if (i < int'(mem_xfer_size) && (mem_address + 64'(i)) < 64'(MEM_SIZE))
               mem[int'(mem_address) + i] <= mem_write_data[8*i +: 8];
         end
      end
   end

   typedef struct {
      logic        write;
      logic [63:0] addr;
      logic [3:0]  size;
      logic [63:0] wdata;
      logic        sgn;
      logic [63:0] rdata;
      logic        err;
      int          lat;
   } vec_t;

   typedef struct {
      logic [63:0] rdata;
      logic        err;
      int          lat;
      int          id;
   } exp_t;

   vec_t vecs[$];
   exp_t exp_q[$];
   int   acc_q[$];

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int n_acc = 0;
   int n_resp = 0;
   int n_en = 0;
   int n_viol = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic add(input logic w, input logic [63:0] a, input logic [3:0] s,
                      input logic [63:0] wd, input logic sg, input logic [63:0] rd,
                      input logic e, input int l);
      vec_t v;
      v.write = w; v.addr = a; v.size = s; v.wdata = wd; v.sgn = sg;
      v.rdata = rd; v.err = e; v.lat = l;
      vecs.push_back(v);
   endtask

   task automatic push_exp(input logic [63:0] rd, input logic e, input int l, input int id);
      exp_t x;
      x.rdata = rd; x.err = e; x.lat = l; x.id = id;
      exp_q.push_back(x);
   endtask

   task automatic drive(input logic w, input logic [63:0] a, input logic [3:0] s,
                        input logic [63:0] wd, input logic sg);
      req_write = w; req_addr = a; req_size = s; req_wdata = wd; req_signed = sg;
   endtask

   // Monitor: acceptance prediction, response scoreboard, memory-port rules.
   // cyc equals the number of rising edges so far at each falling edge.
   always @(negedge clk) begin
      exp_t e;
      int   a;
      cyc++;
      if (req_valid && req_ready && !reset) begin
         acc_q.push_back(cyc + 1);
         n_acc++;
      end
      if (resp_valid) begin
         n_resp++;
         if (exp_q.size() == 0 || acc_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected resp_valid: got 1 expected 0 at cycle %0d", cyc);
         end else begin
            e = exp_q.pop_front();
            a = acc_q.pop_front();
            check($sformatf("req%0d rdata", e.id), resp_rdata, e.rdata);
            check($sformatf("req%0d err", e.id), 64'(resp_err), 64'(e.err));
            check($sformatf("req%0d latency", e.id), 64'(cyc - a), 64'(e.lat));
         end
      end
      if (mem_write_enable || mem_read_enable) begin
         n_en++;
         if (mem_write_enable && mem_read_enable) n_viol++;
         if (!(mem_xfer_size inside {4'd1, 4'd2, 4'd4, 4'd8})) n_viol++;
         if ((mem_address[3:0] & (mem_xfer_size - 4'd1)) != 4'd0) n_viol++;
         if ({1'b0, mem_address} + {61'b0, mem_xfer_size} > 65'(MEM_SIZE)) n_viol++;
      end else if (mem_address != 0 || mem_write_data != 0 || mem_xfer_size != 0) begin
         n_viol++;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int en0;
      int r0;
      int a0;
      int t;

      add(1'b1, 64'h10,  4'd8, 64'h1122334455667788, 1'b0, 64'h0, 1'b0, 1);
      add(1'b0, 64'h10,  4'd8, 64'h0, 1'b0, 64'h1122334455667788, 1'b0, 1);
      add(1'b1, 64'h21,  4'd4, 64'hA1B2C3D4, 1'b0, 64'h0, 1'b0, 4);
      add(1'b0, 64'h21,  4'd4, 64'h0, 1'b1, 64'hFFFFFFFFA1B2C3D4, 1'b0, 4);
      add(1'b0, 64'h21,  4'd4, 64'h0, 1'b0, 64'h00000000A1B2C3D4, 1'b0, 4);
      add(1'b0, 64'h0,   4'd3, 64'h0, 1'b0, 64'h0, 1'b1, 0);
      add(1'b0, 64'h3FC, 4'd8, 64'h0, 1'b0, 64'h0, 1'b1, 0);
      add(1'b0, 64'hFFFFFFFFFFFFFFFF, 4'd2, 64'h0, 1'b0, 64'h0, 1'b1, 0);
      add(1'b1, 64'h3FC, 4'd8, 64'hFFFFFFFFFFFFFFFF, 1'b0, 64'h0, 1'b1, 0);
      add(1'b0, 64'h0,   4'd0, 64'h0, 1'b0, 64'h0, 1'b1, 0);
      add(1'b0, 64'h0,   4'd9, 64'h0, 1'b0, 64'h0, 1'b1, 0);
      add(1'b0, 64'h21,  4'd1, 64'h0, 1'b1, 64'hFFFFFFFFFFFFFFD4, 1'b0, 1);
      add(1'b0, 64'h22,  4'd2, 64'h0, 1'b0, 64'h000000000000B2C3, 1'b0, 1);
      add(1'b0, 64'h23,  4'd2, 64'h0, 1'b1, 64'hFFFFFFFFFFFFA1B2, 1'b0, 2);
      add(1'b0, 64'h20,  4'd4, 64'h0, 1'b1, 64'hFFFFFFFFB2C3D400, 1'b0, 1);
      add(1'b1, 64'h3FE, 4'd2, 64'hDEAD00000000BEEF, 1'b0, 64'h0, 1'b0, 1);
      add(1'b0, 64'h3FE, 4'd2, 64'h0, 1'b1, 64'hFFFFFFFFFFFFBEEF, 1'b0, 1);
      add(1'b0, 64'h13,  4'd8, 64'h0, 1'b0, 64'h0000001122334455, 1'b0, 8);
      add(1'b1, 64'h31,  4'd2, 64'h5A6B, 1'b0, 64'h0, 1'b0, 2);
      add(1'b0, 64'h31,  4'd1, 64'h0, 1'b0, 64'h6B, 1'b0, 1);
      add(1'b0, 64'h32,  4'd1, 64'h0, 1'b1, 64'h5A, 1'b0, 1);

      // Reset state, held and released
      #1;
      check("reset resp_valid", 64'(resp_valid), 64'd0);
      check("reset resp_err", 64'(resp_err), 64'd0);
      check("reset resp_rdata", resp_rdata, 64'd0);
      check("reset mem enables", 64'({mem_write_enable, mem_read_enable}), 64'd0);
      check("reset mem_address", mem_address, 64'd0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      check("ready after reset", 64'(req_ready), 64'd1);

      // Table of single transactions
      foreach (vecs[i]) begin
         en0 = n_en;
         r0  = n_resp;
         push_exp(vecs[i].rdata, vecs[i].err, vecs[i].lat, i);
         drive(vecs[i].write, vecs[i].addr, vecs[i].size, vecs[i].wdata, vecs[i].sgn);
         req_valid = 1'b1;
         @(posedge clk); #1;
         req_valid = 1'b0;
         for (t = 0; t < 30 && n_resp == r0; t++) @(negedge clk);
         if (n_resp == r0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL req%0d response: got none expected one", i);
            exp_q.delete();
            acc_q.delete();
         end
         check($sformatf("req%0d mem cycles", i), 64'(n_en - en0), 64'(vecs[i].lat));
         @(posedge clk); #1;
      end

      check("bytes 0x21..0x24", {32'd0, mem[36], mem[35], mem[34], mem[33]},
            64'h00000000A1B2C3D4);
      check("byte 0x20 untouched", 64'(mem[32]), 64'd0);

      // Back-to-back with req_valid held high across both requests
      a0 = n_acc;
      r0 = n_resp;
      push_exp(64'h1122334455667788, 1'b0, 1, 100);
      push_exp(64'h00000000A1B2C3D4, 1'b0, 4, 101);
      drive(1'b0, 64'h10, 4'd8, 64'h0, 1'b0);
      req_valid = 1'b1;
      @(posedge clk); #1;
      drive(1'b0, 64'h21, 4'd4, 64'h0, 1'b0);
      for (t = 0; t < 30 && n_acc < a0 + 2; t++) @(negedge clk);
      @(posedge clk); #1;
      req_valid = 1'b0;
      for (t = 0; t < 30 && n_resp < r0 + 2; t++) @(negedge clk);
      check("b2b acceptances", 64'(n_acc - a0), 64'd2);
      check("b2b responses", 64'(n_resp - r0), 64'd2);
      @(posedge clk); #1;

      // Reset after two bytes of a split 8-byte store
      r0 = n_resp;
      drive(1'b1, 64'h101, 4'd8, 64'h8877665544332211, 1'b0);
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b1;
      #1;
      check("midsplit reset we", 64'(mem_write_enable), 64'd0);
      check("midsplit reset addr", mem_address, 64'd0);
      check("midsplit reset wdata", mem_write_data, 64'd0);
      check("midsplit reset size", 64'(mem_xfer_size), 64'd0);
      check("midsplit reset ready", 64'(req_ready), 64'd1);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      acc_q.delete();
      repeat (6) @(posedge clk);
      #1;
      check("midsplit no response", 64'(n_resp - r0), 64'd0);
      for (int a = 16'h100; a <= 16'h109; a++) begin
         check($sformatf("midsplit byte %h", a), 64'(mem[a]),
               (a == 16'h101) ? 64'h11 : (a == 16'h102) ? 64'h22 : 64'h0);
      end

      check("memory port rule violations", 64'(n_viol), 64'd0);
      check("leftover expectations", 64'(exp_q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
